// File: rtl/vt52_pkg.sv
// vt52_pkg: shared constants for the text video buffer writer.
//   Text area geometry, fill code, control codes, FSM state encodings
//   and a helper that maps (row, col) to an absolute byte address.
package vt52_pkg;

  localparam logic [12:0] TEXT_BASE = 13'd160;
  localparam logic [12:0] COLS      = 13'd80;
  localparam logic [6:0]  COL_LAST  = 7'd79;
  localparam logic [5:0]  ROWS_24   = 6'd24;
  localparam logic [5:0]  ROWS_38   = 6'd38;
  localparam logic [7:0]  FILL_CHAR = 8'h20;

  localparam logic [7:0]  CH_BS = 8'h08;
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_FF = 8'h0C;
  localparam logic [7:0]  CH_CR = 8'h0D;

  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_PUT    = 3'd1;
  localparam logic [2:0]  ST_SCR_RD = 3'd2;
  localparam logic [2:0]  ST_SCR_WR = 3'd3;
  localparam logic [2:0]  ST_FILL   = 3'd4;
  localparam logic [2:0]  ST_DONE   = 3'd5;

  function automatic logic [12:0] text_addr(input logic [5:0] row, input logic [6:0] col);
    return TEXT_BASE + ({7'd0, row} * COLS) + {6'd0, col};
  endfunction

  function automatic logic [5:0] last_row(input logic lmode);
    return lmode ? (ROWS_38 - 6'd1) : (ROWS_24 - 6'd1);
  endfunction

endpackage

// File: rtl/wb_master_port.sv
// wb_master_port: single-transfer Wishbone master engine.
//   A request is taken when the port is idle; cyc/stb stay high until
//   ack is sampled, then drop for at least one cycle while done_o pulses.
// Ports:
//   clk50mhz, wb_rst_i         clock, async active-high reset
//   req_i/we_i/adr_i/dat_i/sel_i  transfer request (latched on accept)
//   done_o                     one-cycle pulse after ack; rdata_o holds read data
//   wb_*                       Wishbone master signals
module wb_master_port
  import vt52_pkg::*;
(
  input  logic        clk50mhz,
  input  logic        wb_rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [12:0] adr_i,
  input  logic [15:0] dat_i,
  input  logic [1:0]  sel_i,
  output logic        done_o,
  output logic [15:0] rdata_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  logic        act_q, act_d;
  logic        we_q, we_d;
  logic [12:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [1:0]  sel_q, sel_d;
  logic        done_q, done_d;
  logic [15:0] rdata_q, rdata_d;

  always_comb begin
    act_d   = act_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    if (act_q) begin
      // ack outside an active strobe never reaches this branch
      if (wb_ack_i) begin
        act_d   = 1'b0;
        done_d  = 1'b1;
        rdata_d = wb_dat_i;
      end
    end else if (req_i) begin
      act_d = 1'b1;
      we_d  = we_i;
      adr_d = adr_i;
      dat_d = dat_i;
      sel_d = sel_i;
    end
  end

  always_ff @(posedge clk50mhz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      act_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      act_q   <= act_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o   = done_q;
  assign rdata_o  = rdata_q;
  assign wb_adr_o = {3'b000, adr_q};
  assign wb_dat_o = dat_q;
  assign wb_cyc_o = act_q;
  assign wb_stb_o = act_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;

endmodule

// File: rtl/vram_text_writer.sv
// vram_text_writer: turns a character stream into Wishbone writes to the
//   text video buffer, tracks the cursor, runs CR/LF/BS/FF and scrolls by
//   copying rows through the bus.
// Ports:
//   clk50mhz, wb_rst_i        clock, async active-high reset
//   ch_i, ch_valid_i, ch_ready_o  character stream handshake
//   lmode                     0: 24 text rows, 1: 38 text rows
//   cursor_o                  absolute byte address of the cursor
//   busy_o                    inverse of ch_ready_o
//   wb_*                      Wishbone master to the VGA text adapter
//
// state     | meaning
// IDLE      | ready for a character
// PUT       | writing one printable byte at the cursor
// SCR_RD    | scroll: reading word at a
// SCR_WR    | scroll: writing that word one row up
// FILL      | writing fill words from a to end
// DONE      | publishing the new cursor address
module vram_text_writer
  import vt52_pkg::*;
(
  input  logic        clk50mhz,
  input  logic        wb_rst_i,
  input  logic [7:0]  ch_i,
  input  logic        ch_valid_i,
  output logic        ch_ready_o,
  input  logic        lmode,
  output logic [12:0] cursor_o,
  output logic        busy_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  input  logic        wb_ack_i
);

  logic [2:0]  state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [12:0] cursor_q, cursor_d;
  logic        lmode_q, lmode_d;
  logic [7:0]  ch_q, ch_d;
  logic [12:0] a_q, a_d;
  logic [12:0] end_q, end_d;
  logic        wait_q, wait_d;

  logic        req;
  logic        bus_we;
  logic [12:0] bus_adr;
  logic [15:0] bus_dat;
  logic [1:0]  bus_sel;
  logic        done;
  logic [15:0] rdata;
  logic [5:0]  eff_row;
  logic [5:0]  last;

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cursor_d = cursor_q;
    lmode_d  = lmode_q;
    ch_d     = ch_q;
    a_d      = a_q;
    end_d    = end_q;
    wait_d   = wait_q;
    req      = 1'b0;
    bus_we   = 1'b1;
    bus_adr  = a_q;
    bus_dat  = {FILL_CHAR, FILL_CHAR};
    bus_sel  = 2'b11;
    // a row left beyond the 24-row area by a 38->24 switch is pulled back in
    eff_row  = (!lmode && (row_q > last_row(1'b0))) ? last_row(1'b0) : row_q;
    last     = last_row(lmode_q);

    case (state_q)
      ST_IDLE: begin
        if (ch_valid_i) begin
          lmode_d = lmode;
          row_d   = eff_row;
          ch_d    = ch_i;
          case (ch_i)
            CH_CR: begin
              col_d   = 7'd0;
              state_d = ST_DONE;
            end
            CH_BS: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
              state_d = ST_DONE;
            end
            CH_LF: begin
              if (eff_row < last_row(lmode)) begin
                row_d   = eff_row + 6'd1;
                state_d = ST_DONE;
              end else begin
                a_d     = TEXT_BASE + COLS;
                state_d = ST_SCR_RD;
              end
            end
            CH_FF: begin
              col_d   = 7'd0;
              row_d   = 6'd0;
              a_d     = TEXT_BASE;
              end_d   = text_addr(last_row(lmode), COL_LAST - 7'd1);
              state_d = ST_FILL;
            end
            default: begin
              a_d     = text_addr(eff_row, col_q);
              state_d = ST_PUT;
            end
          endcase
        end
      end
      ST_PUT: begin
        bus_dat = {ch_q, ch_q};
        bus_sel = a_q[0] ? 2'b10 : 2'b01;
        req     = !wait_q;
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (done) begin
          wait_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d = 7'd0;
            if (row_q < last) begin
              row_d   = row_q + 6'd1;
              state_d = ST_DONE;
            end else begin
              a_d     = TEXT_BASE + COLS;
              state_d = ST_SCR_RD;
            end
          end else begin
            col_d   = col_q + 7'd1;
            state_d = ST_DONE;
          end
        end
      end
      ST_SCR_RD: begin
        bus_we = 1'b0;
        req    = !wait_q;
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (done) begin
          wait_d  = 1'b0;
          state_d = ST_SCR_WR;
        end
      end
      ST_SCR_WR: begin
        bus_adr = a_q - COLS;
        bus_dat = rdata;
        req     = !wait_q;
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (done) begin
          wait_d = 1'b0;
          if (a_q == text_addr(last, COL_LAST - 7'd1)) begin
            a_d     = text_addr(last, 7'd0);
            end_d   = text_addr(last, COL_LAST - 7'd1);
            state_d = ST_FILL;
          end else begin
            a_d     = a_q + 13'd2;
            state_d = ST_SCR_RD;
          end
        end
      end
      ST_FILL: begin
        req = !wait_q;
        if (!wait_q) begin
          wait_d = 1'b1;
        end else if (done) begin
          wait_d = 1'b0;
          if (a_q == end_q) state_d = ST_DONE;
          else              a_d     = a_q + 13'd2;
        end
      end
      ST_DONE: begin
        cursor_d = text_addr(row_q, col_q);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      cursor_q <= TEXT_BASE;
      lmode_q  <= 1'b0;
      ch_q     <= '0;
      a_q      <= '0;
      end_q    <= '0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cursor_q <= cursor_d;
      lmode_q  <= lmode_d;
      ch_q     <= ch_d;
      a_q      <= a_d;
      end_q    <= end_d;
      wait_q   <= wait_d;
    end
  end

  wb_master_port u_port (
    .clk50mhz (clk50mhz),
    .wb_rst_i (wb_rst_i),
    .req_i    (req),
    .we_i     (bus_we),
    .adr_i    (bus_adr),
    .dat_i    (bus_dat),
    .sel_i    (bus_sel),
    .done_o   (done),
    .rdata_o  (rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i)
  );

  assign ch_ready_o = (state_q == ST_IDLE);
  assign busy_o     = ~ch_ready_o;
  assign cursor_o   = cursor_q;

endmodule

// File: tb/tb_vram_text_writer.sv
// Directed bench for vram_text_writer with a byte-lane Wishbone slave model.
module tb_vram_text_writer;

  logic        clk50mhz = 1'b0;
  logic        wb_rst_i;
  logic [7:0]  ch_i;
  logic        ch_valid_i;
  logic        ch_ready_o;
  logic        lmode;
  logic [12:0] cursor_o;
  logic        busy_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_ack_i;

  always #10 clk50mhz = ~clk50mhz;

  vram_text_writer dut (
    .clk50mhz   (clk50mhz),
    .wb_rst_i   (wb_rst_i),
    .ch_i       (ch_i),
    .ch_valid_i (ch_valid_i),
    .ch_ready_o (ch_ready_o),
    .lmode      (lmode),
    .cursor_o   (cursor_o),
    .busy_o     (busy_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_ack_i   (wb_ack_i)
  );

  // ---------------- slave model ----------------
  logic [15:0] mem [0:4095];
  int          ws, ws_fixed, wcnt;
  logic        rand_ws, init_req, clr_req;
  int          n_rd, n_wr, n_fill, min_fill, max_fill, viol;
  logic [15:0] last_adr, last_dat;
  logic [1:0]  last_sel;
  logic        p_stb, p_we;
  logic [15:0] p_adr, p_dat;
  logic [1:0]  p_sel;

  function automatic logic [7:0] pat(input int a);
    logic [12:0] t;
    t = a[12:0];
    return 8'h80 | {1'b0, t[6:0]};
  endfunction

  function automatic logic [7:0] mbyte(input int a);
    logic [12:0] t;
    logic [15:0] w;
    t = a[12:0];
    w = mem[t[12:1]];
    return t[0] ? w[15:8] : w[7:0];
  endfunction

  assign wb_ack_i = wb_stb_o && (wcnt == ws);
  assign wb_dat_i = mem[wb_adr_o[12:1]];

  always @(posedge clk50mhz) begin
    if (init_req)
      for (int i = 0; i < 4096; i++) mem[i] <= {pat(2*i+1), pat(2*i)};
    if (clr_req) begin
      n_rd <= 0; n_wr <= 0; n_fill <= 0; viol <= 0;
      min_fill <= 65535; max_fill <= 0;
      last_adr <= '0; last_dat <= '0; last_sel <= '0;
    end else if (wb_stb_o) begin
      if (p_stb && (wb_adr_o != p_adr || wb_dat_o != p_dat || wb_sel_o != p_sel ||
                    wb_we_o != p_we || !wb_cyc_o))
        viol <= viol + 1;
      if (wb_ack_i) begin
        wcnt <= 0;
        if (rand_ws) ws <= $urandom_range(0, 5);
        if (wb_we_o) begin
          n_wr <= n_wr + 1;
          if (wb_sel_o[0]) mem[wb_adr_o[12:1]][7:0]  <= wb_dat_o[7:0];
          if (wb_sel_o[1]) mem[wb_adr_o[12:1]][15:8] <= wb_dat_o[15:8];
          last_adr <= wb_adr_o; last_dat <= wb_dat_o; last_sel <= wb_sel_o;
          if (wb_dat_o == 16'h2020 && wb_sel_o == 2'b11) begin
            n_fill <= n_fill + 1;
            if (int'(wb_adr_o) < min_fill) min_fill <= int'(wb_adr_o);
            if (int'(wb_adr_o) > max_fill) max_fill <= int'(wb_adr_o);
          end
        end else begin
          n_rd <= n_rd + 1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
      if (!rand_ws) ws <= ws_fixed;
    end
    p_stb <= wb_stb_o; p_adr <= wb_adr_o; p_dat <= wb_dat_o;
    p_sel <= wb_sel_o; p_we <= wb_we_o;
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_cnt();
    @(negedge clk50mhz); clr_req = 1'b1;
    @(negedge clk50mhz); clr_req = 1'b0;
  endtask

  task automatic init_mem();
    @(negedge clk50mhz); init_req = 1'b1;
    @(negedge clk50mhz); init_req = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ch_ready_o && n < 40000) begin @(negedge clk50mhz); n++; end
    chk(tag, {31'd0, ch_ready_o}, 32'd1);
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk50mhz);
    wait_ready("ready_before_send");
    ch_i = c; ch_valid_i = 1'b1;
    @(negedge clk50mhz);
    ch_valid_i = 1'b0;
    wait_ready("ready_after_send");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e;
    int n;
    ch_i = '0; ch_valid_i = 1'b0; lmode = 1'b0; wb_rst_i = 1'b1;
    init_req = 1'b0; clr_req = 1'b0; rand_ws = 1'b0; ws_fixed = 0;
    repeat (3) @(negedge clk50mhz);
    wb_rst_i = 1'b0;
    @(negedge clk50mhz);
    chk("rst_cursor", 32'(cursor_o), 32'd160);
    chk("rst_ready",  32'(ch_ready_o), 32'd1);
    chk("rst_busy",   32'(busy_o), 32'd0);
    chk("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_sel",    32'(wb_sel_o), 32'd0);
    chk("rst_adr",    32'(wb_adr_o), 32'd0);
    chk("rst_dat",    32'(wb_dat_o), 32'd0);

    // 'A' at col 0
    clear_cnt(); send(8'h41);
    chk("A_writes", n_wr, 1);
    chk("A_reads",  n_rd, 0);
    chk("A_adr",    32'(last_adr), 32'd160);
    chk("A_sel",    32'(last_sel), 32'h1);
    chk("A_dat",    32'(last_dat), 32'h4141);
    chk("A_cursor", 32'(cursor_o), 32'd161);

    // 'B' at col 1 uses the odd byte lane
    clear_cnt(); send(8'h42);
    chk("B_adr",    32'(last_adr), 32'd161);
    chk("B_sel",    32'(last_sel), 32'h2);
    chk("B_dat",    32'(last_dat), 32'h4242);
    chk("B_cursor", 32'(cursor_o), 32'd162);

    // CR: home column, no bus traffic
    clear_cnt(); send(8'h0D);
    chk("CR_cursor", 32'(cursor_o), 32'd160);
    chk("CR_bus",    n_wr + n_rd, 0);

    // a full row of printables wraps to row 1 col 0
    ws_fixed = 2;
    clear_cnt();
    for (int i = 0; i < 80; i++) send(8'(8'h30 + i));
    ws_fixed = 0;
    chk("row_cursor", 32'(cursor_o), 32'd240);
    chk("row_writes", n_wr, 80);
    chk("row_first",  32'(mbyte(160)), 32'h30);
    chk("row_last",   32'(mbyte(239)), 32'h7F);

    // to row 3, col 5, then CR / BS
    send(8'h0A); send(8'h0A);
    chk("LF_cursor", 32'(cursor_o), 32'd400);
    for (int i = 0; i < 5; i++) send(8'h78);
    chk("col5_cursor", 32'(cursor_o), 32'd405);
    clear_cnt(); send(8'h0D);
    chk("CR3_cursor", 32'(cursor_o), 32'd400);
    chk("CR3_bus",    n_wr + n_rd, 0);
    clear_cnt(); send(8'h08);
    chk("BS0_cursor", 32'(cursor_o), 32'd400);
    chk("BS0_bus",    n_wr + n_rd, 0);
    send(8'h79); send(8'h79); send(8'h08);
    chk("BS2_cursor", 32'(cursor_o), 32'd401);

    // down to row 23 (24-row mode)
    send(8'h0D);
    for (int i = 0; i < 20; i++) send(8'h0A);
    chk("row23_cursor", 32'(cursor_o), 32'd2000);

    // LF on the last row scrolls, with random wait states
    init_mem(); clear_cnt(); rand_ws = 1'b1;
    send(8'h0A);
    rand_ws = 1'b0;
    chk("scr_reads",  n_rd, 920);
    chk("scr_writes", n_wr, 960);
    chk("scr_fills",  n_fill, 40);
    chk("scr_cursor", 32'(cursor_o), 32'd2000);
    chk("scr_stable", viol, 0);
    e = 0;
    for (int k = 0; k < 23; k++)
      for (int j = 0; j < 80; j++)
        if (mbyte(160 + k*80 + j) !== pat(240 + k*80 + j)) e++;
    chk("scr_shift", e, 0);
    e = 0;
    for (int j = 0; j < 80; j++) if (mbyte(2000 + j) !== 8'h20) e++;
    chk("scr_lastrow", e, 0);
    e = 0;
    for (int a = 0; a < 160; a++) if (mbyte(a) !== pat(a)) e++;
    for (int a = 2080; a < 3200; a++) if (mbyte(a) !== pat(a)) e++;
    chk("scr_untouched", e, 0);

    // FF in 38-row mode clears the whole text area
    init_mem(); clear_cnt(); lmode = 1'b1;
    send(8'h0C);
    chk("ff_writes", n_wr, 1520);
    chk("ff_fills",  n_fill, 1520);
    chk("ff_reads",  n_rd, 0);
    chk("ff_min",    min_fill, 160);
    chk("ff_max",    max_fill, 3198);
    chk("ff_cursor", 32'(cursor_o), 32'd160);
    e = 0;
    for (int a = 160; a < 3200; a++) if (mbyte(a) !== 8'h20) e++;
    for (int a = 0; a < 160; a++) if (mbyte(a) !== pat(a)) e++;
    chk("ff_content", e, 0);

    // row 30 in 38-row mode clamps to 23 after switching to 24 rows
    for (int i = 0; i < 30; i++) send(8'h0A);
    chk("r30_cursor", 32'(cursor_o), 32'd2560);
    lmode = 1'b0;
    send(8'h0D);
    chk("clamp_cursor", 32'(cursor_o), 32'd2000);

    // reset asserted while a scroll write is on the bus
    rand_ws = 1'b1;
    @(negedge clk50mhz);
    wait_ready("ready_before_rst_scroll");
    ch_i = 8'h0A; ch_valid_i = 1'b1;
    @(negedge clk50mhz);
    ch_valid_i = 1'b0;
    n = 0;
    while (!(wb_stb_o && wb_we_o) && n < 500) begin @(negedge clk50mhz); n++; end
    chk("scrwr_seen", {31'd0, wb_stb_o && wb_we_o}, 32'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("mid_rst_stb",    {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    chk("mid_rst_cursor", 32'(cursor_o), 32'd160);
    chk("mid_rst_ready",  32'(ch_ready_o), 32'd1);
    @(negedge clk50mhz);
    wb_rst_i = 1'b0;
    rand_ws = 1'b0;
    clear_cnt(); send(8'h41);
    chk("post_rst_adr",    32'(last_adr), 32'd160);
    chk("post_rst_cursor", 32'(cursor_o), 32'd161);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
